// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: accepts one RD/WR request, waits WAIT_STATES
// cycles, completes the access, then holds Ready until the requester drops its strobes.
module data_memory_responder #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int WAIT_STATES   = 2
) (
    input  logic                     DataMemResp_CLOCK_50,
    input  logic                     DataMemResp_RESET_InLow,
    input  logic                     DataMemResp_Selector_RD,
    input  logic                     DataMemResp_Selector_WR,
    input  logic [DATAWIDTH_BUS-1:0] DataMemResp_Address_In,
    input  logic [DATAWIDTH_BUS-1:0] DataMemResp_Data_In,
    output logic [DATAWIDTH_BUS-1:0] DataMemResp_Data_Out,
    output logic                     DataMemResp_Ready,
    output logic                     DataMemResp_Busy,
    output logic                     DataMemResp_Error
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    stateT                    state;
    stateT                    nextState;
    logic [3:0]               waitCount;
    logic                     latchedRd;
    logic                     latchedWr;
    logic [DATAWIDTH_BUS-1:0] latchedAddr;
    logic [DATAWIDTH_BUS-1:0] latchedData;
    logic [DATAWIDTH_BUS-1:0] dataOutReg;
    logic                     errorReg;
    logic [DATAWIDTH_BUS-1:0] mem [2**ADDR_WIDTH];

    logic                     request;
    logic                     completeNow;
    logic                     accessError;
    logic [ADDR_WIDTH-1:0]    wordIndex;
    logic [DATAWIDTH_BUS-1:0] highAddrBits;

    assign request      = DataMemResp_Selector_RD | DataMemResp_Selector_WR;
    assign completeNow  = (state == WAIT) && (waitCount == 4'd0);
    assign wordIndex    = latchedAddr[ADDR_WIDTH+1:2];
    assign highAddrBits = latchedAddr >> (ADDR_WIDTH + 2);
    // Conflicting strobes, a misaligned byte address, or one beyond the array all fail.
    assign accessError  = (latchedRd & latchedWr)
                        | (latchedAddr[1:0] != 2'b00)
                        | (highAddrBits != '0);

    always_ff @(posedge DataMemResp_CLOCK_50 or negedge DataMemResp_RESET_InLow) begin
        if (!DataMemResp_RESET_InLow) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (request) nextState = WAIT;
            WAIT: if (waitCount == 4'd0) nextState = DONE;
            DONE: if (!request) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request capture, wait-state countdown and completion-time status/read data.
    always_ff @(posedge DataMemResp_CLOCK_50 or negedge DataMemResp_RESET_InLow) begin
        if (!DataMemResp_RESET_InLow) begin
            waitCount   <= 4'd0;
            latchedRd   <= 1'b0;
            latchedWr   <= 1'b0;
            latchedAddr <= '0;
            latchedData <= '0;
            dataOutReg  <= '0;
            errorReg    <= 1'b0;
        end else if (state == IDLE) begin
            if (request) begin
                latchedRd   <= DataMemResp_Selector_RD;
                latchedWr   <= DataMemResp_Selector_WR;
                latchedAddr <= DataMemResp_Address_In;
                latchedData <= DataMemResp_Data_In;
                waitCount   <= WAIT_LOAD;
            end
        end else if (state == WAIT) begin
            if (waitCount != 4'd0) begin
                waitCount <= waitCount - 4'd1;
            end else begin
                errorReg <= accessError;
                if (!accessError && latchedRd) begin
                    dataOutReg <= mem[wordIndex];
                end
            end
        end
    end

    // The array has no reset; a write only lands on a clean completion edge.
    always_ff @(posedge DataMemResp_CLOCK_50) begin
        if (completeNow && !accessError && latchedWr) begin
            mem[wordIndex] <= latchedData;
        end
    end

    assign DataMemResp_Data_Out = dataOutReg;
    assign DataMemResp_Ready    = (state == DONE);
    assign DataMemResp_Busy     = (state != IDLE);
    assign DataMemResp_Error    = errorReg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a 2-wait-state instance and a
// zero-wait-state instance share clock and reset; a small memory model predicts results.
module tb_data_memory_responder;

    localparam int WS_SLOW = 2;
    localparam int WS_FAST = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        err;
        int          latency;
    } expT;

    logic clk = 1'b0;
    logic rstN;

    logic        slowRd, slowWr, fastRd, fastWr;
    logic [31:0] slowAddr, slowDin, fastAddr, fastDin;
    logic [31:0] slowDout, fastDout;
    logic        slowReady, slowBusy, slowErr;
    logic        fastReady, fastBusy, fastErr;

    logic [31:0] modelMem [2][256];
    logic [31:0] lastRead [2];
    expT         sbQ [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DATAWIDTH_BUS(32), .ADDR_WIDTH(8), .WAIT_STATES(WS_SLOW)) dutSlow (
        .DataMemResp_CLOCK_50    (clk),
        .DataMemResp_RESET_InLow (rstN),
        .DataMemResp_Selector_RD (slowRd),
        .DataMemResp_Selector_WR (slowWr),
        .DataMemResp_Address_In  (slowAddr),
        .DataMemResp_Data_In     (slowDin),
        .DataMemResp_Data_Out    (slowDout),
        .DataMemResp_Ready       (slowReady),
        .DataMemResp_Busy        (slowBusy),
        .DataMemResp_Error       (slowErr)
    );

    data_memory_responder #(.DATAWIDTH_BUS(32), .ADDR_WIDTH(8), .WAIT_STATES(WS_FAST)) dutFast (
        .DataMemResp_CLOCK_50    (clk),
        .DataMemResp_RESET_InLow (rstN),
        .DataMemResp_Selector_RD (fastRd),
        .DataMemResp_Selector_WR (fastWr),
        .DataMemResp_Address_In  (fastAddr),
        .DataMemResp_Data_In     (fastDin),
        .DataMemResp_Data_Out    (fastDout),
        .DataMemResp_Ready       (fastReady),
        .DataMemResp_Busy        (fastBusy),
        .DataMemResp_Error       (fastErr)
    );

    function automatic logic getReady(input int idx);
        return (idx == 0) ? slowReady : fastReady;
    endfunction

    function automatic logic getBusy(input int idx);
        return (idx == 0) ? slowBusy : fastBusy;
    endfunction

    function automatic logic getErr(input int idx);
        return (idx == 0) ? slowErr : fastErr;
    endfunction

    function automatic logic [31:0] getDout(input int idx);
        return (idx == 0) ? slowDout : fastDout;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic driveInputs(input int idx, input logic rdV, input logic wrV,
                               input logic [31:0] a, input logic [31:0] d);
        if (idx == 0) begin
            slowRd = rdV; slowWr = wrV; slowAddr = a; slowDin = d;
        end else begin
            fastRd = rdV; fastWr = wrV; fastAddr = a; fastDin = d;
        end
    endtask

    // Predicts the outcome, runs one full handshake and compares against the scoreboard.
    task automatic applyStimulus(input int idx, input logic rdV, input logic wrV,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input int holdCycles, input logic moveAddr);
        expT e;
        expT got;
        int  k;
        logic isErr;
        isErr = (rdV && wrV) || (a[1:0] != 2'b00) || ((a >> 10) != 32'd0);
        if (!isErr && wrV) modelMem[idx][a[9:2]] = d;
        if (!isErr && rdV) lastRead[idx] = modelMem[idx][a[9:2]];
        e.idx     = idx;
        e.data    = lastRead[idx];
        e.err     = isErr;
        e.latency = 1 + ((idx == 0) ? WS_SLOW : WS_FAST);
        sbQ.push_back(e);

        @(negedge clk);
        driveInputs(idx, rdV, wrV, a, d);
        @(posedge clk);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (moveAddr && k == 1) driveInputs(idx, rdV, wrV, a ^ 32'h30, 32'hBAD0BAD0);
        end while (!getReady(idx) && k < 40);

        got = sbQ.pop_front();
        checkOutput("latency", k, got.latency);
        checkOutput("dataOut", getDout(got.idx), got.data);
        checkOutput("error", {31'd0, getErr(got.idx)}, {31'd0, got.err});

        repeat (holdCycles) begin
            @(posedge clk);
            #1;
            checkOutput("holdReady", {31'd0, getReady(idx)}, 32'd1);
            checkOutput("holdData", getDout(idx), got.data);
        end

        @(negedge clk);
        driveInputs(idx, 1'b0, 1'b0, a, d);
        @(posedge clk);
        #1;
        checkOutput("readyDrop", {31'd0, getReady(idx)}, 32'd0);
        checkOutput("busyDrop", {31'd0, getBusy(idx)}, 32'd0);
    endtask

    task automatic checkCleared(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput({tag, "Dout"}, getDout(i), 32'd0);
            checkOutput({tag, "Ready"}, {31'd0, getReady(i)}, 32'd0);
            checkOutput({tag, "Busy"}, {31'd0, getBusy(i)}, 32'd0);
            checkOutput({tag, "Error"}, {31'd0, getErr(i)}, 32'd0);
        end
    endtask

    initial begin
        rstN = 1'b0;
        driveInputs(0, 1'b0, 1'b0, 32'd0, 32'd0);
        driveInputs(1, 1'b0, 1'b0, 32'd0, 32'd0);
        lastRead[0] = 32'd0;
        lastRead[1] = 32'd0;
        #12;
        checkCleared("reset");
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("dataHeld", slowDout, 32'hDEADBEEF);

        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h5A5A0001, 0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'hFFFF0000, 0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 32'h400, 32'h77777777, 0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 5, 1'b1);

        applyStimulus(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'hAAAA5555, 0, 1'b0);
        @(negedge clk);
        driveInputs(0, 1'b0, 1'b1, 32'h30, 32'h11112222);
        @(posedge clk);
        #1;
        checkOutput("abortBusy", {31'd0, slowBusy}, 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkCleared("midReset");
        @(negedge clk);
        driveInputs(0, 1'b0, 1'b0, 32'd0, 32'd0);
        rstN = 1'b1;
        lastRead[0] = 32'd0;
        lastRead[1] = 32'd0;

        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0, 0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0);

        checkOutput("scoreboardEmpty", sbQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
